// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  // Arbiter FSM: IDLE between bursts, BURST while one requester owns the port.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Widest requester vector the arbiter supports.
  localparam int MAX_N_REQ = 8;

  // One-hot of idx within an n-bit field; callers cast down to their width.
  function automatic logic [MAX_N_REQ-1:0] onehot(input int idx, input int n);
    logic [MAX_N_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_N_REQ; i++) begin
      v[i] = (i == idx) && (i < n);
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_rr_ptr,
  output logic                     o_valid,
  output logic [$clog2(N_REQ)-1:0] o_index
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  // Scan offsets from farthest to nearest so the nearest hit to rr_ptr wins.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(N_REQ);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (i_req[w_idx]) begin
        o_valid = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin scheduler for the async FIFO write port.
// Handshake: requester i presents req[i]/data/last and holds them stable; the
// word transfers in the cycle ack[i] is high (w_en is the same event toward the
// FIFO). A requester may drop req only to abandon its burst.
// FSM state is visible through busy (1 = BURST) together with gnt and owner.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0]             last,
  input  logic [N_REQ*DATA_SIZE-1:0]   data,
  input  logic                         full,
  input  logic                         almost_full,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_REQ-1:0]             ack,
  output logic                         w_en,
  output logic [DATA_SIZE-1:0]         w_data,
  output logic [$clog2(N_REQ)-1:0]     owner,
  output logic                         busy
);

  localparam int OWN_W = $clog2(N_REQ);
  localparam int CNT_W = 4;

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [OWN_W-1:0] r_owner;
  logic [OWN_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_pick_valid;
  logic [OWN_W-1:0] w_pick_idx;
  logic [N_REQ-1:0] w_owner_oh;
  logic [N_REQ-1:0] w_pick_oh;
  logic             w_start;
  logic             w_accept;
  logic             w_abandon;
  logic             w_count_hit;
  logic             w_done;
  logic [OWN_W-1:0] w_next_ptr;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_index  (w_pick_idx)
  );

  assign w_owner_oh = N_REQ'(onehot(int'(r_owner), N_REQ));
  assign w_pick_oh  = N_REQ'(onehot(int'(w_pick_idx), N_REQ));

  // New grants are admitted only with headroom in the FIFO.
  assign w_start     = (r_state == IDLE) && (|req) && w_pick_valid && !almost_full && !full;
  // Within a burst only full stalls; almost_full is ignored here on purpose.
  assign w_accept    = (r_state == BURST) && req[r_owner] && !full;
  assign w_abandon   = (r_state == BURST) && !req[r_owner];
  assign w_count_hit = (r_count + CNT_W'(1)) == CNT_W'(MAX_BURST);
  // last and the burst limit together still give a single exit.
  assign w_done      = w_abandon || (w_accept && (last[r_owner] || w_count_hit));
  assign w_next_ptr  = (r_owner == OWN_W'(N_REQ - 1)) ? '0 : r_owner + OWN_W'(1);

  // Outputs: write strobe and ack are combinational so the FIFO samples them on the next edge.
  assign ack    = w_accept ? w_owner_oh : '0;
  assign w_en   = w_accept;
  assign w_data = data[int'(r_owner)*DATA_SIZE +: DATA_SIZE];
  assign gnt    = r_gnt;
  assign owner  = r_owner;
  assign busy   = (r_state == BURST);

  // Arbiter FSM with registered grant, owner, round-robin pointer and word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= BURST;
            r_owner <= w_pick_idx;
            r_gnt   <= w_pick_oh;
            r_count <= '0;
          end
        end
        BURST: begin
          if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
          end
          if (w_done) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed multi-cycle sequences,
// and randomized traffic checked against a transaction-level model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  // Clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*DW-1:0] data;
  logic            full;
  logic            almost_full;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic            w_en;
  logic [DW-1:0]   w_data;
  logic [1:0]      owner;
  logic            busy;

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .DATA_SIZE (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .last        (last),
    .data        (data),
    .full        (full),
    .almost_full (almost_full),
    .gnt         (gnt),
    .ack         (ack),
    .w_en        (w_en),
    .w_data      (w_data),
    .owner       (owner),
    .busy        (busy)
  );

  typedef struct {
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*DW-1:0] data;
    logic            full;
    logic            af;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic            wen;
    logic [DW-1:0]   wdata;
    logic [1:0]      owner;
    logic            own_chk;
    logic            busy;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  vec_t tbl[11];
  int wc[N];

  function automatic vec_t mk(input logic r, input logic [N-1:0] rq, input logic [N-1:0] la,
                              input logic [N*DW-1:0] d, input logic fu, input logic af,
                              input logic [N-1:0] g, input logic [N-1:0] a, input logic we,
                              input logic [DW-1:0] wd, input logic [1:0] ow, input logic oc,
                              input logic bz);
    vec_t v;
    v.rst = r; v.req = rq; v.last = la; v.data = d; v.full = fu; v.af = af;
    v.gnt = g; v.ack = a; v.wen = we; v.wdata = wd; v.owner = ow; v.own_chk = oc; v.busy = bz;
    return v;
  endfunction

  function automatic logic [N*DW-1:0] build_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(16 * i + wc[i]);
    return d;
  endfunction

  // Driver: apply one row, check outputs mid-cycle, advance past the edge.
  task automatic apply(input vec_t v, input string tag);
    logic ok;
    rst = v.rst; req = v.req; last = v.last; data = v.data; full = v.full; almost_full = v.af;
    @(negedge clk);
    ok = (gnt === v.gnt) && (ack === v.ack) && (w_en === v.wen) && (busy === v.busy)
         && (!v.wen || (w_data === v.wdata)) && (!v.own_chk || (owner === v.owner));
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got gnt=%b ack=%b w_en=%b w_data=%h owner=%0d busy=%b, want gnt=%b ack=%b w_en=%b w_data=%h owner=%0d busy=%b",
               tag, gnt, ack, w_en, w_data, owner, busy,
               v.gnt, v.ack, v.wen, v.wdata, v.owner, v.busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; last = '0; data = '0; full = 1'b0; almost_full = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model state (transaction level)
  bit m_busy;
  int m_owner, m_cnt, m_rr;
  bit pend[N];
  logic [DW-1:0] pdat[N];
  bit plast[N];

  task automatic random_phase(input int cycles);
    logic [N-1:0] e_gnt, e_ack;
    bit acc;
    logic [DW-1:0] e_wd, got;
    bit ok;
    int ow;
    m_busy = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < cycles; c++) begin
      // Producers: new words, occasional abandonment
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1; pdat[i] = DW'($urandom); plast[i] = ($urandom_range(0, 3) == 0);
        end else if (pend[i] && $urandom_range(0, 39) == 0) begin
          pend[i] = 0;
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      full = ($urandom_range(0, 5) == 0);
      almost_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        req[i] = pend[i]; last[i] = plast[i]; data[i*DW +: DW] = pdat[i];
      end
      // Expectations for this cycle
      e_gnt = m_busy ? N'(1 << m_owner) : '0;
      acc = m_busy && req[m_owner] && !full;
      e_ack = acc ? N'(1 << m_owner) : '0;
      e_wd = data[m_owner*DW +: DW];
      @(negedge clk);
      ok = (gnt === e_gnt) && (ack === e_ack) && (w_en === acc) && (busy === m_busy)
           && (!m_busy || (owner === 2'(m_owner)));
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand cycle %0d: got gnt=%b ack=%b w_en=%b owner=%0d busy=%b, want gnt=%b ack=%b w_en=%b owner=%0d busy=%b",
                 c, gnt, ack, w_en, owner, busy, e_gnt, e_ack, acc, m_owner, m_busy);
      end
      // Scoreboard of words written to the FIFO
      if (acc) exp_q.push_back(e_wd);
      if (w_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand write %0d: got unexpected word %h, want no write", c, w_data);
        end else begin
          got = exp_q.pop_front();
          if (w_data !== got) begin
            errors++;
            $display("FAIL rand write %0d: got w_data=%h, want %h", c, w_data, got);
          end
        end
      end
      // Advance producers and model
      if (acc) pend[m_owner] = 0;
      if (rst) begin
        m_busy = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
      end else if (!m_busy) begin
        if ((|req) && !almost_full && !full) begin
          ow = -1;
          for (int k = 0; k < N; k++) begin
            if (ow < 0 && req[(m_rr + k) % N]) ow = (m_rr + k) % N;
          end
          m_busy = 1; m_owner = ow; m_cnt = 0;
        end
      end else if (!req[m_owner]) begin
        m_busy = 0; m_rr = (m_owner + 1) % N;
      end else if (acc) begin
        m_cnt++;
        if (last[m_owner] || m_cnt == MB) begin
          m_busy = 0; m_rr = (m_owner + 1) % N;
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand drain: got %0d words unwritten, want 0", exp_q.size());
    end
  endtask

  initial begin
    do_reset();

    // Single 3-word burst, then round-robin pointer checks
    tbl[0]  = mk(1, 4'b0000, 4'b0000, 32'h0,        0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1, 0);
    tbl[1]  = mk(0, 4'b0001, 4'b0000, 32'h000000A1, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1, 0);
    tbl[2]  = mk(0, 4'b0001, 4'b0000, 32'h000000A1, 0, 0, 4'b0001, 4'b0001, 1, 8'hA1, 0, 1, 1);
    tbl[3]  = mk(0, 4'b0001, 4'b0000, 32'h000000A2, 0, 0, 4'b0001, 4'b0001, 1, 8'hA2, 0, 1, 1);
    tbl[4]  = mk(0, 4'b0001, 4'b0001, 32'h000000A3, 0, 0, 4'b0001, 4'b0001, 1, 8'hA3, 0, 1, 1);
    tbl[5]  = mk(0, 4'b0000, 4'b0000, 32'h0,        0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
    tbl[6]  = mk(0, 4'b0011, 4'b0010, 32'h0000B1A4, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
    tbl[7]  = mk(0, 4'b0011, 4'b0010, 32'h0000B1A4, 0, 0, 4'b0010, 4'b0010, 1, 8'hB1, 1, 1, 1);
    tbl[8]  = mk(0, 4'b0001, 4'b0001, 32'h000000A4, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
    tbl[9]  = mk(0, 4'b0001, 4'b0001, 32'h000000A4, 0, 0, 4'b0001, 4'b0001, 1, 8'hA4, 0, 1, 1);
    tbl[10] = mk(0, 4'b0000, 4'b0000, 32'h0,        0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("table row %0d", i));

    // All requesters continuous: order 0,1,2,3,0, MB words each, one bubble between
    do_reset();
    for (int i = 0; i < N; i++) wc[i] = 0;
    for (int b = 0; b < 5; b++) begin
      int o;
      o = b % N;
      apply(mk(0, 4'b1111, 4'b0000, build_data(), 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0),
            $sformatf("rr bubble %0d", b));
      for (int w = 0; w < MB; w++) begin
        apply(mk(0, 4'b1111, 4'b0000, build_data(), 0, 0, N'(1 << o), N'(1 << o), 1,
                 DW'(16 * o + wc[o]), 2'(o), 1, 1), $sformatf("rr burst %0d word %0d", b, w));
        wc[o]++;
      end
    end

    // full stall for 5 cycles after word 2
    do_reset();
    apply(mk(0, 4'b0001, 0, 32'hC0, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0), "stall idle");
    apply(mk(0, 4'b0001, 0, 32'hC0, 0, 0, 4'b0001, 4'b0001, 1, 8'hC0, 0, 1, 1), "stall word1");
    apply(mk(0, 4'b0001, 0, 32'hC1, 0, 0, 4'b0001, 4'b0001, 1, 8'hC1, 0, 1, 1), "stall word2");
    for (int s = 0; s < 5; s++)
      apply(mk(0, 4'b0001, 0, 32'hC2, 1, 0, 4'b0001, 4'b0000, 0, 8'h00, 0, 1, 1), $sformatf("stall full %0d", s));
    apply(mk(0, 4'b0001, 0, 32'hC2, 0, 0, 4'b0001, 4'b0001, 1, 8'hC2, 0, 1, 1), "stall word3");
    apply(mk(0, 4'b0001, 0, 32'hC3, 0, 0, 4'b0001, 4'b0001, 1, 8'hC3, 0, 1, 1), "stall word4");
    apply(mk(0, 4'b0001, 0, 32'hC4, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0), "stall end idle");

    // almost_full blocks new grants only
    do_reset();
    for (int s = 0; s < 3; s++)
      apply(mk(0, 4'b0110, 0, 32'h00E2D100, 0, 1, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0), $sformatf("af hold %0d", s));
    apply(mk(0, 4'b0110, 4'b0110, 32'h00E2D100, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0), "af release");
    apply(mk(0, 4'b0110, 4'b0110, 32'h00E2D100, 0, 0, 4'b0010, 4'b0010, 1, 8'hD1, 1, 1, 1), "af grant1");
    apply(mk(0, 4'b0100, 4'b0100, 32'h00E2D100, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0), "af bubble");
    apply(mk(0, 4'b0100, 4'b0100, 32'h00E2D100, 0, 0, 4'b0100, 4'b0100, 1, 8'hE2, 2, 1, 1), "af grant2");

    // Owner abandons after one word
    do_reset();
    apply(mk(0, 4'b0011, 0, 32'h0000F1F0, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0), "abandon idle");
    apply(mk(0, 4'b0011, 0, 32'h0000F1F0, 0, 0, 4'b0001, 4'b0001, 1, 8'hF0, 0, 1, 1), "abandon word1");
    apply(mk(0, 4'b0010, 0, 32'h0000F1F0, 0, 0, 4'b0001, 4'b0000, 0, 8'h00, 0, 1, 1), "abandon drop");
    apply(mk(0, 4'b0011, 0, 32'h0000F1F0, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0), "abandon bubble");
    apply(mk(0, 4'b0011, 4'b0010, 32'h0000F1F0, 0, 0, 4'b0010, 4'b0010, 1, 8'hF1, 1, 1, 1), "abandon next");

    // Reset during burst word 2 restarts arbitration at requester 0
    do_reset();
    apply(mk(0, 4'b0011, 4'b0011, 32'h00001110, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0), "rst idle");
    apply(mk(0, 4'b0011, 4'b0011, 32'h00001110, 0, 0, 4'b0001, 4'b0001, 1, 8'h10, 0, 1, 1), "rst burst0");
    apply(mk(0, 4'b0011, 4'b0000, 32'h00001110, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0), "rst bubble");
    apply(mk(0, 4'b0011, 4'b0000, 32'h00001110, 0, 0, 4'b0010, 4'b0010, 1, 8'h11, 1, 1, 1), "rst word1");
    apply(mk(1, 4'b0011, 4'b0000, 32'h00001110, 0, 0, 4'b0010, 4'b0010, 1, 8'h11, 1, 1, 1), "rst word2");
    apply(mk(0, 4'b0011, 4'b0011, 32'h00001110, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1, 0), "rst after");
    apply(mk(0, 4'b0011, 4'b0011, 32'h00001110, 0, 0, 4'b0001, 4'b0001, 1, 8'h10, 0, 1, 1), "rst restart");

    // Randomized traffic against the model
    do_reset();
    random_phase(3000);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
